// File: rtl/counter_pkg.sv
// -----------------------------------------------------------------------------
// counter_pkg
// Shared definitions for the counter sequencer slice.
//   DEFAULT_WIDTH : default bit width of limit, count and laps
//   state_e       : sequencer state encoding (IDLE, RUN)
// -----------------------------------------------------------------------------
package counter_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/sync_counter.sv
// -----------------------------------------------------------------------------
// sync_counter
// WIDTH-bit synchronous up-counter. clr has priority over en; with neither
// asserted the value holds. Counting wraps modulo 2^WIDTH.
// Ports:
//   CLK   : rising-edge clock
//   RST   : asynchronous active-high reset (count -> 0)
//   clr   : synchronous clear to 0
//   en    : increment enable
//   count : registered count value
// -----------------------------------------------------------------------------
module sync_counter #(
    parameter int WIDTH = counter_pkg::DEFAULT_WIDTH
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             clr,
    input  logic             en,
    output logic [WIDTH-1:0] count
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] count_d;
    logic [WIDTH-1:0] count_q;

    // Next-count selection: clear, increment or hold.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = {WIDTH{1'b0}};
        end else if (en) begin
            count_d = count_q + ONE;
        end else begin
            count_d = count_q;
        end
    end

    // Count register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            count_q <= {WIDTH{1'b0}};
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/counter_sequencer.sv
// -----------------------------------------------------------------------------
// counter_sequencer
// Sequences a count from 0 up to a latched limit under a start/busy/done
// handshake, with one-shot or auto-reload operation, pause and abort.
// Ports:
//   CLK    : rising-edge clock
//   RST    : asynchronous active-high reset
//   start  : run request, honoured only in IDLE with limit != 0
//   pause  : hold count/laps while high (RUN only)
//   abort  : terminate immediately; highest priority
//   reload : auto-reload mode, latched with start
//   limit  : terminal count, latched with start
//   count  : current count (registered)
//   busy   : high while in RUN (registered)
//   done   : one-cycle pulse after a terminal edge (registered)
//   laps   : completed laps in current/last run, saturating (registered)
// -----------------------------------------------------------------------------
module counter_sequencer
    import counter_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             start,
    input  logic             pause,
    input  logic             abort,
    input  logic             reload,
    input  logic [WIDTH-1:0] limit,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] laps
);

    localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONES = {WIDTH{1'b1}};

    // Lap counter sticks at all-ones instead of wrapping.
    function automatic logic [WIDTH-1:0] sat_inc(input logic [WIDTH-1:0] v);
        if (v == ONES) begin
            return v;
        end else begin
            return v + ONE;
        end
    endfunction

    state_e           state_d,  state_q;
    logic [WIDTH-1:0] limit_d,  limit_q;
    logic             reload_d, reload_q;
    logic [WIDTH-1:0] laps_d,   laps_q;
    logic             busy_d,   busy_q;
    logic             done_d,   done_q;
    logic             cnt_clr_s;
    logic             cnt_en_s;
    logic [WIDTH-1:0] count_s;

    sync_counter #(
        .WIDTH (WIDTH)
    ) u_count (
        .CLK   (CLK),
        .RST   (RST),
        .clr   (cnt_clr_s),
        .en    (cnt_en_s),
        .count (count_s)
    );

    // Next-state and output decode. Pause is checked ahead of the terminal
    // compare so a paused run sitting on its limit neither ends nor pulses done.
    always_comb begin
        state_d   = state_q;
        limit_d   = limit_q;
        reload_d  = reload_q;
        laps_d    = laps_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        cnt_clr_s = 1'b0;
        cnt_en_s  = 1'b0;
        case (state_q)
            IDLE: begin
                if (abort) begin
                    cnt_clr_s = 1'b1;
                end else if (start && (limit != ZERO)) begin
                    limit_d   = limit;
                    reload_d  = reload;
                    laps_d    = ZERO;
                    busy_d    = 1'b1;
                    cnt_clr_s = 1'b1;
                    state_d   = RUN;
                end else begin
                    busy_d = 1'b0;
                end
            end
            RUN: begin
                if (abort) begin
                    cnt_clr_s = 1'b1;
                    busy_d    = 1'b0;
                    state_d   = IDLE;
                end else if (pause) begin
                    busy_d = 1'b1;
                end else if (count_s == limit_q) begin
                    done_d = 1'b1;
                    laps_d = sat_inc(laps_q);
                    if (reload_q) begin
                        cnt_clr_s = 1'b1;
                    end else begin
                        busy_d  = 1'b0;
                        state_d = IDLE;
                    end
                end else begin
                    cnt_en_s = 1'b1;
                end
            end
            default: begin
                cnt_clr_s = 1'b1;
                busy_d    = 1'b0;
                state_d   = IDLE;
            end
        endcase
    end

    // State, latched run parameters and registered outputs.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= IDLE;
            limit_q  <= ZERO;
            reload_q <= 1'b0;
            laps_q   <= ZERO;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            limit_q  <= limit_d;
            reload_q <= reload_d;
            laps_q   <= laps_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign count = count_s;
    assign busy  = busy_q;
    assign done  = done_q;
    assign laps  = laps_q;

endmodule

// File: tb/tb_counter_sequencer.sv
// -----------------------------------------------------------------------------
// tb_counter_sequencer
// Table-driven bench: each record holds the inputs applied before a rising
// edge and the outputs expected just after it. Expected records go into a
// scoreboard queue when driven and are popped and compared after the edge.
// -----------------------------------------------------------------------------
module tb_counter_sequencer;

    localparam int W = 8;

    logic         CLK = 1'b0;
    logic         RST;
    logic         start;
    logic         pause;
    logic         abort;
    logic         reload;
    logic [W-1:0] limit;
    logic [W-1:0] count;
    logic         busy;
    logic         done;
    logic [W-1:0] laps;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic         start;
        logic         pause;
        logic         abort;
        logic         reload;
        logic [W-1:0] limit;
        logic [W-1:0] e_count;
        logic         e_busy;
        logic         e_done;
        logic [W-1:0] e_laps;
    } vec_t;

    vec_t tbl[$];
    vec_t sb[$];

    counter_sequencer #(.WIDTH(W)) dut (
        .CLK    (CLK),
        .RST    (RST),
        .start  (start),
        .pause  (pause),
        .abort  (abort),
        .reload (reload),
        .limit  (limit),
        .count  (count),
        .busy   (busy),
        .done   (done),
        .laps   (laps)
    );

    always #5 CLK = ~CLK;

    function automatic vec_t mk(input int s, input int p, input int a, input int r,
                                input int lim, input int c, input int b, input int d,
                                input int l);
        vec_t v;
        v.start   = s[0];
        v.pause   = p[0];
        v.abort   = a[0];
        v.reload  = r[0];
        v.limit   = lim[W-1:0];
        v.e_count = c[W-1:0];
        v.e_busy  = b[0];
        v.e_done  = d[0];
        v.e_laps  = l[W-1:0];
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_outs(input string tag, input vec_t e);
        chk({tag, "_count"}, 32'(count), 32'(e.e_count));
        chk({tag, "_busy"},  32'(busy),  32'(e.e_busy));
        chk({tag, "_done"},  32'(done),  32'(e.e_done));
        chk({tag, "_laps"},  32'(laps),  32'(e.e_laps));
    endtask

    // Drive one record, let one edge pass, compare against the scoreboard.
    task automatic cycle(input vec_t v, input string tag);
        vec_t e;
        start  = v.start;
        pause  = v.pause;
        abort  = v.abort;
        reload = v.reload;
        limit  = v.limit;
        sb.push_back(v);
        @(posedge CLK);
        #1;
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            check_outs(tag, e);
        end
    endtask

    task automatic run_tbl(input string tag);
        for (int i = 0; i < tbl.size(); i++) begin
            cycle(tbl[i], $sformatf("%s[%0d]", tag, i));
        end
        tbl.delete();
    endtask

    initial begin
        RST    = 1'b1;
        start  = 1'b0;
        pause  = 1'b0;
        abort  = 1'b0;
        reload = 1'b0;
        limit  = '0;
        #12;
        check_outs("reset", mk(0,0,0,0,0, 0,0,0,0));
        @(negedge CLK);
        RST = 1'b0;

        // Idle after reset, then one-shot limit=3, then abort in IDLE.
        tbl.push_back(mk(0,0,0,0,0, 0,0,0,0));
        tbl.push_back(mk(1,0,0,0,3, 0,1,0,0));
        tbl.push_back(mk(0,0,0,0,0, 1,1,0,0));
        tbl.push_back(mk(0,0,0,0,0, 2,1,0,0));
        tbl.push_back(mk(0,0,0,0,0, 3,1,0,0));
        tbl.push_back(mk(0,0,0,0,0, 3,0,1,1));
        tbl.push_back(mk(0,0,0,0,0, 3,0,0,1));
        tbl.push_back(mk(0,0,1,0,0, 0,0,0,1));
        run_tbl("oneshot");

        // Auto-reload limit=2 for 9 cycles, then abort (laps holds).
        cycle(mk(1,0,0,1,2, 0,1,0,0), "reload_start");
        for (int i = 1; i <= 9; i++) begin
            cycle(mk(0,0,0,0,0, i % 3, 1, (i % 3 == 0) ? 1 : 0, i / 3),
                  $sformatf("reload[%0d]", i));
        end
        cycle(mk(0,0,1,0,0, 0,0,0,3), "reload_abort");

        // Pause while sitting on the terminal count.
        tbl.push_back(mk(1,0,0,0,4, 0,1,0,0));
        tbl.push_back(mk(0,0,0,0,0, 1,1,0,0));
        tbl.push_back(mk(0,0,0,0,0, 2,1,0,0));
        tbl.push_back(mk(0,0,0,0,0, 3,1,0,0));
        tbl.push_back(mk(0,0,0,0,0, 4,1,0,0));
        tbl.push_back(mk(0,1,0,0,0, 4,1,0,0));
        tbl.push_back(mk(0,1,0,0,0, 4,1,0,0));
        tbl.push_back(mk(0,1,0,0,0, 4,1,0,0));
        tbl.push_back(mk(0,0,0,0,0, 4,0,1,1));
        tbl.push_back(mk(0,0,0,0,0, 4,0,0,1));
        run_tbl("pause");

        // Abort coinciding with terminal, then start with limit=0.
        tbl.push_back(mk(1,0,0,0,5, 0,1,0,0));
        tbl.push_back(mk(0,0,0,0,0, 1,1,0,0));
        tbl.push_back(mk(0,0,0,0,0, 2,1,0,0));
        tbl.push_back(mk(0,0,0,0,0, 3,1,0,0));
        tbl.push_back(mk(0,0,0,0,0, 4,1,0,0));
        tbl.push_back(mk(0,0,0,0,0, 5,1,0,0));
        tbl.push_back(mk(0,0,1,0,0, 0,0,0,0));
        tbl.push_back(mk(0,0,0,0,0, 0,0,0,0));
        tbl.push_back(mk(1,0,0,0,0, 0,0,0,0));
        tbl.push_back(mk(0,0,0,0,0, 0,0,0,0));
        // abort beats start in IDLE; abort beats pause in RUN
        tbl.push_back(mk(1,0,1,0,3, 0,0,0,0));
        tbl.push_back(mk(1,0,0,0,3, 0,1,0,0));
        tbl.push_back(mk(0,0,0,0,0, 1,1,0,0));
        tbl.push_back(mk(0,1,1,0,0, 0,0,0,0));
        run_tbl("abort");

        // Back-to-back with start held and limit changed mid-run.
        tbl.push_back(mk(1,0,0,0,2, 0,1,0,0));
        tbl.push_back(mk(1,0,0,1,7, 1,1,0,0));
        tbl.push_back(mk(1,0,0,0,7, 2,1,0,0));
        tbl.push_back(mk(1,0,0,0,7, 2,0,1,1));
        tbl.push_back(mk(1,0,0,0,7, 0,1,0,0));
        tbl.push_back(mk(0,0,0,0,0, 1,1,0,0));
        tbl.push_back(mk(0,0,0,0,0, 2,1,0,0));
        tbl.push_back(mk(0,0,0,0,0, 3,1,0,0));
        tbl.push_back(mk(0,0,0,0,0, 4,1,0,0));
        tbl.push_back(mk(0,0,0,0,0, 5,1,0,0));
        tbl.push_back(mk(0,0,0,0,0, 6,1,0,0));
        tbl.push_back(mk(0,0,0,0,0, 7,1,0,0));
        tbl.push_back(mk(0,0,0,0,0, 7,0,1,1));
        run_tbl("b2b");

        // Saturation: limit=1 auto-reload, laps reaches 255 and sticks.
        cycle(mk(1,0,0,1,1, 0,1,0,0), "sat_start");
        for (int i = 1; i <= 601; i++) begin
            cycle(mk(0,0,0,0,0, i % 2, 1, (i % 2 == 0) ? 1 : 0,
                     (i / 2 > 255) ? 255 : i / 2),
                  $sformatf("sat[%0d]", i));
        end

        // Asynchronous reset between edges while mid-run.
        #2;
        RST = 1'b1;
        #1;
        check_outs("async_rst", mk(0,0,0,0,0, 0,0,0,0));
        @(posedge CLK);
        #1;
        check_outs("rst_held", mk(0,0,0,0,0, 0,0,0,0));
        #3;
        RST = 1'b0;
        tbl.push_back(mk(0,0,0,0,0, 0,0,0,0));
        tbl.push_back(mk(0,0,0,0,0, 0,0,0,0));
        tbl.push_back(mk(0,0,0,0,0, 0,0,0,0));
        run_tbl("post_rst");

        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
